// File: rtl/hex_msg_scroller.sv
`default_nettype none
// ============================================================================
// Module  : hex_msg_scroller
// Brief   : Scrolls a MSG_LEN-character message (alphabet d, E, 1, blank)
//           across NUM_HEX active-low seven-segment displays. A rate divider
//           paces the scroll; a run/stop/hold FSM controls it, with an
//           optional pause after every full rotation.
// Revision: 1.0 - initial release
// ============================================================================
module hex_msg_scroller #(
   parameter int NUM_HEX    = 6,
   parameter int MSG_LEN    = 8,
   parameter int TICK_DIV   = 50000000,
   parameter int HOLD_TICKS = 2,
   localparam int HW        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic [2*MSG_LEN-1:0]   msg_in,
   input  logic                   load,
   input  logic                   run,
   input  logic                   step,
   input  logic                   dir,
   input  logic                   hold_en,
   output logic [7*NUM_HEX-1:0]   hex_out,
   output logic [HW-1:0]          head,
   output logic                   wrap
);

   localparam int DW  = $clog2(TICK_DIV);
   localparam int HCW = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                 state_q;
   logic [2*MSG_LEN-1:0]   buf_q;
   logic [HW-1:0]          head_q;
   logic                   wrap_q;
   logic [DW-1:0]          div_q;
   logic [HCW-1:0]         hold_q;

   logic [HW-1:0]          head_d;
   logic [HCW-1:0]         hold_d;
   logic                   tick;

   // Segment pattern for one 2-bit character code, bits g..a, active-low.
   function automatic logic [6:0] seg_decode(input logic [1:0] code);
      logic [6:0] seg;
      case (code)
         2'b00:   seg = 7'b0100001;  // d
         2'b01:   seg = 7'b0000110;  // E
         2'b10:   seg = 7'b1111001;  // 1
         default: seg = 7'b1111111;  // blank
      endcase
      return seg;
   endfunction

   // The divider only advances outside STOP, so a tick can only occur while scrolling or holding.
   assign tick   = (state_q != ST_STOP) && (div_q == DW'(TICK_DIV - 1));
   assign hold_d = hold_q + 1'b1;

   // Next head position for an advance; explicit wrap keeps non-power-of-2 lengths exact.
   always_comb begin
      head_d = head_q;
      if (MSG_LEN == 1) begin
         head_d = '0;
      end else if (!dir) begin
         head_d = (head_q == HW'(MSG_LEN - 1)) ? '0 : head_q + 1'b1;
      end else begin
         head_d = (head_q == '0) ? HW'(MSG_LEN - 1) : head_q - 1'b1;
      end
   end

   // Run/stop/hold FSM together with the buffer, head, divider and wrap pulse.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= ST_STOP;
         buf_q   <= '1;
         head_q  <= '0;
         wrap_q  <= 1'b0;
         div_q   <= '0;
         hold_q  <= '0;
      end else begin
         wrap_q <= 1'b0;
         if (load) begin
            // A load overrides any same-cycle advance and ends a pending hold.
            buf_q  <= msg_in;
            head_q <= '0;
            div_q  <= '0;
            if (state_q == ST_HOLD) begin
               state_q <= ST_RUN;
            end
         end else begin
            case (state_q)
               ST_STOP: begin
                  div_q <= '0;
                  if (run) begin
                     state_q <= ST_RUN;
                  end else if (step) begin
                     head_q <= head_d;
                     wrap_q <= (head_d == '0);
                  end
               end
               ST_RUN: begin
                  if (!run) begin
                     state_q <= ST_STOP;
                     div_q   <= '0;
                  end else if (tick) begin
                     div_q  <= '0;
                     head_q <= head_d;
                     wrap_q <= (head_d == '0);
                     if ((head_d == '0) && hold_en) begin
                        state_q <= ST_HOLD;
                        hold_q  <= '0;
                     end
                  end else begin
                     div_q <= div_q + 1'b1;
                  end
               end
               ST_HOLD: begin
                  if (!run) begin
                     state_q <= ST_STOP;
                     div_q   <= '0;
                  end else if (tick) begin
                     // The tick that completes the hold resumes scrolling without advancing.
                     div_q  <= '0;
                     hold_q <= hold_d;
                     if (hold_d == HCW'(HOLD_TICKS)) begin
                        state_q <= ST_RUN;
                     end
                  end else begin
                     div_q <= div_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_STOP;
                  div_q   <= '0;
               end
            endcase
         end
      end
   end

   // Display k (k = NUM_HEX-1 is leftmost) shows character (head + NUM_HEX-1-k) mod MSG_LEN.
   for (genvar k = 0; k < NUM_HEX; k++) begin : g_disp
      logic [31:0] idx;
      logic [1:0]  code;

      // Select this display's character from the rotating buffer.
      always_comb begin
         idx  = (32'(head_q) + 32'(NUM_HEX - 1 - k)) % 32'(MSG_LEN);
         code = buf_q[2*idx +: 2];
      end

      assign hex_out[7*k +: 7] = seg_decode(code);
   end

   assign head = head_q;
   assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_msg_scroller.sv
`default_nettype none
// ============================================================================
// Module  : tb_hex_msg_scroller
// Brief   : Self-checking bench for hex_msg_scroller. Two instances (MSG_LEN 8
//           and 5) share stimulus; a behavioural model tracks both and is
//           compared every cycle, with literal expectations at key points.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hex_msg_scroller;

   localparam int NH = 6;
   localparam int TD = 4;
   localparam int HT = 2;

   logic        clock = 1'b0;
   logic        resetn, load, run, step, dir, hold_en;
   logic [15:0] msg;
   logic [41:0] hex8, hex5;
   logic [2:0]  head8, head5;
   logic        wrap8, wrap5;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clock = ~clock;

   hex_msg_scroller #(.NUM_HEX(NH), .MSG_LEN(8), .TICK_DIV(TD), .HOLD_TICKS(HT)) u8 (
      .clock(clock), .resetn(resetn), .msg_in(msg), .load(load), .run(run),
      .step(step), .dir(dir), .hold_en(hold_en), .hex_out(hex8), .head(head8), .wrap(wrap8)
   );

   hex_msg_scroller #(.NUM_HEX(NH), .MSG_LEN(5), .TICK_DIV(TD), .HOLD_TICKS(HT)) u5 (
      .clock(clock), .resetn(resetn), .msg_in(msg[9:0]), .load(load), .run(run),
      .step(step), .dir(dir), .hold_en(hold_en), .hex_out(hex5), .head(head5), .wrap(wrap5)
   );

   // ---------------- behavioural model ----------------
   int         ml [2] = '{8, 5};
   int         m_head [2];
   int         m_mode [2];   // 0 stopped, 1 scrolling, 2 holding
   int         m_cnt [2];    // cycles counted towards the next tick
   int         m_holds [2];
   bit         m_wrap [2];
   logic [1:0] m_ch [2][16];

   function automatic logic [6:0] seg(input logic [1:0] c);
      case (c)
         2'b00:   return 7'b0100001;
         2'b01:   return 7'b0000110;
         2'b10:   return 7'b1111001;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [41:0] exp_hex(input int i);
      logic [41:0] r;
      r = '0;
      for (int k = 0; k < NH; k++)
         r[7*k +: 7] = seg(m_ch[i][(m_head[i] + NH - 1 - k) % ml[i]]);
      return r;
   endfunction

   task automatic model_step(input int i);
      int adv;   // 0 none, 1 by step, 2 by tick
      adv = 0;
      if (!resetn) begin
         m_head[i] = 0; m_mode[i] = 0; m_cnt[i] = 0; m_holds[i] = 0; m_wrap[i] = 0;
         for (int j = 0; j < 16; j++) m_ch[i][j] = 2'b11;
         return;
      end
      m_wrap[i] = 0;
      if (load) begin
         for (int j = 0; j < ml[i]; j++) m_ch[i][j] = msg[2*j +: 2];
         m_head[i] = 0;
         m_cnt[i]  = 0;
         if (m_mode[i] == 2) m_mode[i] = 1;
      end else if (m_mode[i] == 0) begin
         if (run) m_mode[i] = 1;
         else if (step) adv = 1;
      end else if (!run) begin
         m_mode[i] = 0;
         m_cnt[i]  = 0;
      end else begin
         m_cnt[i]++;
         if (m_cnt[i] == TD) begin
            m_cnt[i] = 0;
            if (m_mode[i] == 1) adv = 2;
            else begin
               m_holds[i]++;
               if (m_holds[i] == HT) m_mode[i] = 1;
            end
         end
      end
      if (adv != 0) begin
         m_head[i] = dir ? (m_head[i] + ml[i] - 1) % ml[i] : (m_head[i] + 1) % ml[i];
         if (m_head[i] == 0) begin
            m_wrap[i] = 1;
            if (adv == 2 && hold_en) begin
               m_mode[i]  = 2;
               m_holds[i] = 0;
            end
         end
      end
   endtask

   always @(posedge clock) begin
      model_step(0);
      model_step(1);
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         check("model_hex8",  64'(hex8),  64'(exp_hex(0)));
         check("model_head8", 64'(head8), 64'(m_head[0]));
         check("model_wrap8", 64'(wrap8), 64'(m_wrap[0]));
         check("model_hex5",  64'(hex5),  64'(exp_hex(1)));
         check("model_head5", 64'(head5), 64'(m_head[1]));
         check("model_wrap5", 64'(wrap5), 64'(m_wrap[1]));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      resetn = 1'b0; run = 1'b1; load = 1'b1; step = 1'b0;
      dir = 1'b0; hold_en = 1'b0; msg = 16'hE4E4;   // d,E,1,blank,d,E,1,blank
      cyc(2);
      chk_en = 1'b1;
      check("rst_hex8",  64'(hex8),  64'({42{1'b1}}));
      check("rst_head8", 64'(head8), 64'(0));
      check("rst_wrap8", 64'(wrap8), 64'(0));
      check("rst_hex5",  64'(hex5),  64'({42{1'b1}}));
      resetn = 1'b1; run = 1'b0; load = 1'b0;
      cyc(1);
      check("rst_nolatch", 64'(hex8), 64'({42{1'b1}}));

      // Load and display
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      check("load_disp5", 64'(hex8[41:35]), 64'(7'b0100001));
      check("load_disp4", 64'(hex8[34:28]), 64'(7'b0000110));
      check("load_disp3", 64'(hex8[27:21]), 64'(7'b1111001));
      check("load_disp2", 64'(hex8[20:14]), 64'(7'b1111111));

      // Scroll left, one advance every 4 cycles
      run = 1'b1;
      cyc(5);
      check("left_head_first", 64'(head8), 64'(1));
      check("left_disp5_first", 64'(hex8[41:35]), 64'(7'b0000110));
      for (int n = 2; n <= 8; n++) begin
         cyc(4);
         check("left_head", 64'(head8), 64'(n % 8));
      end
      check("left_wrap", 64'(wrap8), 64'(1));
      check("left_disp5_wrap", 64'(hex8[41:35]), 64'(7'b0100001));
      cyc(1);
      check("left_wrap_pulse", 64'(wrap8), 64'(0));

      // Scroll right on the 5-character instance
      load = 1'b1; dir = 1'b1;
      cyc(1);
      load = 1'b0;
      check("right_head5_load", 64'(head5), 64'(0));
      cyc(4);
      check("right_head5_a", 64'(head5), 64'(4));
      check("right_head8_a", 64'(head8), 64'(7));
      cyc(4);
      check("right_head5_b", 64'(head5), 64'(3));
      run = 1'b0;
      cyc(1);
      step = 1'b1; cyc(1); step = 1'b0; cyc(1);
      step = 1'b1; cyc(1); step = 1'b0;
      check("step_head5", 64'(head5), 64'(1));
      check("step_head8", 64'(head8), 64'(4));
      run = 1'b1; step = 1'b1;
      cyc(2);
      step = 1'b0;
      check("step_ignored", 64'(head5), 64'(1));

      // Hold after a full rotation
      run = 1'b0;
      cyc(1);
      dir = 1'b0; hold_en = 1'b1; run = 1'b1;
      cyc(17);
      check("hold_head8", 64'(head8), 64'(0));
      check("hold_wrap8", 64'(wrap8), 64'(1));
      check("hold_wrap5", 64'(wrap5), 64'(1));
      for (int n = 1; n <= 11; n++) begin
         cyc(1);
         check("hold_stay", 64'(head8), 64'(0));
      end
      cyc(1);
      check("hold_resume", 64'(head8), 64'(1));

      // Load coincident with a tick
      cyc(11);
      check("prio_head_before", 64'(head8), 64'(3));
      load = 1'b1; msg = 16'h5555;
      cyc(1);
      load = 1'b0;
      check("prio_head", 64'(head8), 64'(0));
      check("prio_wrap", 64'(wrap8), 64'(0));
      check("prio_hex", 64'(hex8), 64'({6{7'b0000110}}));

      // Reset during hold
      cyc(32);
      check("prio_wrap_hold", 64'(wrap8), 64'(1));
      cyc(2);
      resetn = 1'b0;
      cyc(1);
      check("rst_hold_hex", 64'(hex8), 64'({42{1'b1}}));
      check("rst_hold_head", 64'(head8), 64'(0));
      resetn = 1'b1; run = 1'b0;
      cyc(2);
      check("rst_hold_stop", 64'(hex8), 64'({42{1'b1}}));

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
